// File: rtl/ext_uart_tx.sv
// ============================================================================
// Module  : ext_uart_tx
// Brief   : External-bus byte target that queues writes into a FIFO and
//           transmits them as 8N1 UART frames.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ext_uart_tx #(
  parameter int          FIFO_AW   = 4,
  parameter int unsigned DIV_RESET = 104
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] i_ext_addr,
  input  logic [7:0]  i_ext_data,
  input  logic        i_ext_wstrb,
  input  logic        i_ext_valid,
  output logic        o_ext_ready,
  output logic        o_uart_tx,
  output logic        o_tx_busy
);

  localparam int             DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW+1)'(1);
  localparam logic [15:0]    DIV_INIT = 16'(DIV_RESET);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]       fifo_mem [DEPTH];
  logic [FIFO_AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic             ack_hold_q, ack_hold_d;
  logic [15:0]      div_q, div_d;
  logic [15:0]      timer_q, timer_d;
  logic [15:0]      bit_len_q, bit_len_d;
  logic [1:0]       state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;

  logic             fifo_full, fifo_empty;
  logic             accept, push, pop;
  logic [15:0]      div_eff;
  logic             unused_addr;

  assign unused_addr = ^i_ext_addr[15:2];

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                      (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);

  // ack_hold masks the extra valid cycle the initiator needs to see ready.
  assign o_ext_ready = i_ext_valid & ~ack_hold_q &
                       ~(i_ext_wstrb & (i_ext_addr[1:0] == 2'd0) & fifo_full);
  assign accept      = i_ext_valid & o_ext_ready;
  assign push        = accept & i_ext_wstrb & (i_ext_addr[1:0] == 2'd0);
  assign pop         = (state_q == ST_IDLE) & ~fifo_empty;
  assign div_eff     = (div_q < 16'd2) ? 16'd1 : div_q;
  assign o_tx_busy   = ~fifo_empty | (state_q != ST_IDLE);

  always_comb begin
    ack_hold_d = accept;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    div_d      = div_q;
    timer_d    = timer_q;
    bit_len_d  = bit_len_q;
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;

    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;

    if (accept && i_ext_wstrb) begin
      if (i_ext_addr[1:0] == 2'd1) div_d[7:0]  = i_ext_data;
      if (i_ext_addr[1:0] == 2'd2) div_d[15:8] = i_ext_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          // Bit length is frozen per frame so divisor writes apply next frame.
          shift_d   = fifo_mem[rptr_q[FIFO_AW-1:0]];
          bit_len_d = div_eff;
          timer_d   = div_eff - 16'd1;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (timer_q == 16'd0) begin
          timer_d   = bit_len_q - 16'd1;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (timer_q == 16'd0) begin
          timer_d = bit_len_q - 16'd1;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        if (timer_q == 16'd0) state_d = ST_IDLE;
        else                  timer_d = timer_q - 16'd1;
      end
    endcase
  end

  always_comb begin
    o_uart_tx = 1'b1;
    case (state_q)
      ST_START: o_uart_tx = 1'b0;
      ST_DATA:  o_uart_tx = shift_q[0];
      default:  o_uart_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ack_hold_q <= 1'b0;
      div_q      <= DIV_INIT;
      timer_q    <= '0;
      bit_len_q  <= 16'd1;
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ack_hold_q <= ack_hold_d;
      div_q      <= div_d;
      timer_q    <= timer_d;
      bit_len_q  <= bit_len_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q[FIFO_AW-1:0]] <= i_ext_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_ext_uart_tx.sv
// ============================================================================
// Module  : tb_ext_uart_tx
// Brief   : Self-checking bench for ext_uart_tx (frame decoder + byte queue).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ext_uart_tx;

  localparam int FIFO_AW   = 2;
  localparam int DIV_RESET = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] i_ext_addr = '0;
  logic [7:0]  i_ext_data = '0;
  logic        i_ext_wstrb = 1'b0;
  logic        i_ext_valid = 1'b0;
  logic        o_ext_ready, o_uart_tx, o_tx_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];
  int          gaps[$];
  logic [15:0] div_reg;
  logic        mon_busy = 1'b0;

  always #5 clk = ~clk;

  ext_uart_tx #(.FIFO_AW(FIFO_AW), .DIV_RESET(DIV_RESET)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .i_ext_addr (i_ext_addr),
    .i_ext_data (i_ext_data),
    .i_ext_wstrb(i_ext_wstrb),
    .i_ext_valid(i_ext_valid),
    .o_ext_ready(o_ext_ready),
    .o_uart_tx  (o_uart_tx),
    .o_tx_busy  (o_tx_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int div_eff();
    return (div_reg < 16'd2) ? 1 : int'(div_reg);
  endfunction

  // Frame decoder: each detected start bit consumes one queued byte and the
  // line is compared sample-by-sample against {stop, byte, start}.
  initial begin : monitor
    logic [9:0] pat;
    int pos, d, gap;
    logic in_frame;
    in_frame = 1'b0; pos = 0; d = 1; gap = 0; pat = '1;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        in_frame = 1'b0;
        gap = 0;
      end else if (!in_frame) begin
        if (o_uart_tx === 1'b0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
            pat = 10'h200;
          end else begin
            pat = {1'b1, exp_q.pop_front(), 1'b0};
          end
          gaps.push_back(gap);
          d = div_eff();
          pos = 1;
          in_frame = 1'b1;
        end else begin
          gap++;
        end
      end else begin
        check("tx_bit", {31'd0, o_uart_tx}, {31'd0, pat[pos / d]});
        pos++;
        if (pos == 10 * d) begin
          in_frame = 1'b0;
          gap = 0;
        end
      end
      mon_busy = in_frame;
    end
  end

  // Starts and ends just after a rising edge; holds valid one cycle past accept.
  task automatic bus_op(input logic [15:0] a, input logic [7:0] d, input logic w,
                        output int waited);
    logic ok;
    i_ext_addr = a; i_ext_data = d; i_ext_wstrb = w; i_ext_valid = 1'b1;
    waited = 0; ok = 1'b0;
    while (!ok && waited <= 400) begin
      @(negedge clk);
      if (o_ext_ready) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      if (w && a[1:0] == 2'd0)      exp_q.push_back(d);
      else if (w && a[1:0] == 2'd1) div_reg[7:0] = d;
      else if (w && a[1:0] == 2'd2) div_reg[15:8] = d;
      @(negedge clk);
      check("ack_hold_ready", {31'd0, o_ext_ready}, 32'd0);
    end
    @(posedge clk); #1;
    i_ext_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((o_tx_busy || mon_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("idle_tx", {31'd0, o_uart_tx}, 32'd1);
    check("idle_queue_empty", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        wstrb;
    logic        exp_busy;
  } vec_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        vecs[7];
    int          w;
    logic [7:0]  b2b[6];
    logic [7:0]  dv_tab[5];
    logic [31:0] rnd;
    logic [7:0]  dv;
    int          nops, sel;

    vecs[0] = '{16'h0000, 8'h11, 1'b0, 1'b0};
    vecs[1] = '{16'h0001, 8'h22, 1'b0, 1'b0};
    vecs[2] = '{16'h0002, 8'h33, 1'b0, 1'b0};
    vecs[3] = '{16'h0003, 8'h44, 1'b0, 1'b0};
    vecs[4] = '{16'hABC3, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 8'h5A, 1'b1, 1'b1};
    vecs[6] = '{16'hFFFC, 8'h3C, 1'b1, 1'b1};
    b2b     = '{8'h01, 8'h80, 8'hF0, 8'h0F, 8'hAA, 8'h96};
    dv_tab  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5};

    div_reg = 16'(DIV_RESET);
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;

    // Reset state held with no traffic
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("rst_tx", {31'd0, o_uart_tx}, 32'd1);
      check("rst_ready", {31'd0, o_ext_ready}, 32'd0);
      check("rst_busy", {31'd0, o_tx_busy}, 32'd0);
    end
    @(posedge clk); #1;

    // Single byte at the reset divisor
    bus_op(16'h0000, 8'h55, 1'b1, w);
    check("w55_wait", w, 32'd0);
    @(negedge clk);
    check("w55_ready_after", {31'd0, o_ext_ready}, 32'd0);
    @(posedge clk); #1;
    wait_idle();

    // Divisor 3 then 0xA5
    bus_op(16'h0001, 8'h03, 1'b1, w);
    bus_op(16'h0002, 8'h00, 1'b1, w);
    bus_op(16'h0000, 8'hA5, 1'b1, w);
    wait_idle();

    // Table: reads and ignored writes have no side effect
    bus_op(16'h0001, 8'h04, 1'b1, w);
    for (int i = 0; i < 7; i++) begin
      bus_op(vecs[i].addr, vecs[i].data, vecs[i].wstrb, w);
      check("vec_wait", w, 32'd0);
      @(negedge clk);
      check("vec_busy", {31'd0, o_tx_busy}, {31'd0, vecs[i].exp_busy});
      @(posedge clk); #1;
      if (vecs[i].exp_busy) wait_idle();
    end

    // Single push with held valid produces exactly one frame
    gaps.delete();
    bus_op(16'h0000, 8'hE7, 1'b1, w);
    wait_idle();
    check("single_frame_count", gaps.size(), 32'd1);

    // FIFO full stall at DIV=2, depth 4
    bus_op(16'h0001, 8'h02, 1'b1, w);
    bus_op(16'h0002, 8'h00, 1'b1, w);
    gaps.delete();
    for (int k = 0; k < 6; k++) begin
      bus_op(16'h0000, b2b[k], 1'b1, w);
      check("b2b_wait", w, (k == 5) ? 32'd13 : 32'd0);
    end
    wait_idle();
    check("b2b_frames", gaps.size(), 32'd6);
    for (int k = 1; k < 6; k++)
      if (k < gaps.size()) check("b2b_gap", gaps[k], 32'd1);

    // Randomized traffic against the byte-queue model
    for (int r = 0; r < 4; r++) begin
      dv = dv_tab[$urandom_range(0, 4)];
      bus_op(16'h0001, dv, 1'b1, w);
      bus_op(16'h0002, 8'h00, 1'b1, w);
      nops = $urandom_range(6, 12);
      for (int n = 0; n < nops; n++) begin
        rnd = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 6)      bus_op({rnd[31:18], 2'b00}, rnd[7:0], 1'b1, w);
        else if (sel < 8) bus_op(rnd[31:16], rnd[7:0], 1'b0, w);
        else              bus_op({rnd[31:18], 2'b11}, rnd[7:0], 1'b1, w);
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
      end
      wait_idle();
    end

    // Reset in the middle of the data bits with bytes still queued
    bus_op(16'h0001, 8'h03, 1'b1, w);
    bus_op(16'h0000, 8'hC3, 1'b1, w);
    bus_op(16'h0000, 8'h81, 1'b1, w);
    bus_op(16'h0000, 8'h7E, 1'b1, w);
    begin
      int n;
      n = 0;
      while (!mon_busy && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) check("start_timeout", 32'd0, 32'd1);
    end
    repeat (10) @(posedge clk);
    #2;
    check("pre_reset_tx", {31'd0, o_uart_tx}, 32'd0);
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_tx", {31'd0, o_uart_tx}, 32'd1);
    check("async_rst_busy", {31'd0, o_tx_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    div_reg = 16'(DIV_RESET);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("post_rst_busy", {31'd0, o_tx_busy}, 32'd0);
      check("post_rst_tx", {31'd0, o_uart_tx}, 32'd1);
    end
    @(posedge clk); #1;
    gaps.delete();
    bus_op(16'h0000, 8'h96, 1'b1, w);
    wait_idle();
    check("post_rst_frames", gaps.size(), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
